freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
Reciprocal of the clock divider: measures the frequency of an external digital signal instead of generating one.
- Synchronises `sig_in` into the `clk_50MHz` domain and counts its rising edges over a fixed gate window of GATE_CYCLES system cycles (1 s at 50 MHz).
- Publishes the latched count as `freq` with a one-cycle `valid` strobe.
- Feeds display/readout logic in the clock/timer designs.

Parameters:
- GATE_CYCLES, 50000000: gate window length in `clk_50MHz` cycles (≥ 2).
- CNT_W, 32: width of the edge counter and of `freq`.
- SYNC_STAGES, 2: synchroniser flop count for `sig_in` (≥ 2).

Ports:
- clk_50MHz  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable; level-sensitive.
- sig_in  input  1  asynchronous signal under measurement.
- freq  output  CNT_W  last completed measurement (edges per gate window).
- valid  output  1  one-cycle pulse when `freq` updates.
- overflow  output  1  last completed measurement saturated.
- busy  output  1  high while a gate window is open or being latched.

Behaviour:
- Reset (reset=0, async): all outputs, synchroniser flops, edge-detect flop and both counters go to 0; FSM goes to IDLE.
- Synchroniser: `sig_in` passes through SYNC_STAGES flops, then one extra flop for edge detect.
  - `edge` = sync_out & ~prev.
  - Latency from `sig_in` rise to `edge` is SYNC_STAGES+1 cycles.
  - Valid input range: high and low each ≥ 1 clk period (sig_in < 25 MHz); faster input is undefined.
- Gate counter width = $clog2(GATE_CYCLES). Edge counter is CNT_W bits and saturates at 2^CNT_W−1, setting an internal `sat` flag.
- FSM states:
  - IDLE:
    - Counters held at 0.
    - en=1 → GATE on the next cycle.
  - GATE:
    - `gate_cnt` increments every cycle; `edge_cnt` increments on each `edge` cycle.
    - An edge coinciding with `gate_cnt == GATE_CYCLES-1` is counted.
    - In that cycle, transition → LATCH.
    - The window is exactly GATE_CYCLES cycles.
  - LATCH (1 cycle):
    - `freq` ← `edge_cnt`, `overflow` ← `sat`, `valid` = 1.
    - Counters and `sat` cleared.
    - An edge in this cycle is not counted (dead cycle).
    - Next state: en=1 → GATE; en=0 → IDLE.
- Continuous mode: en held high gives one measurement every GATE_CYCLES+1 cycles.
- en=0 during GATE: abort.
  - Next state IDLE; counters cleared.
  - `freq`/`overflow` unchanged; no `valid`.
- `busy` = (state != IDLE), registered with the state.
- `valid` is never high for two consecutive cycles.
- `freq`/`overflow` change only in the LATCH cycle.
- Reset mid-GATE or mid-LATCH: immediate clear, no `valid`; measurement restarts only after reset release and en=1.

Decomposition:
- Package `freq_meter_pkg`:
  - state enum: IDLE, GATE, LATCH.
  - default constants: GATE_CYCLES_1S=50000000, CNT_W_DEF=32.
- Sub-module `sig_sync_edge`: parameterised SYNC_STAGES synchroniser plus rising-edge detector, async active-low reset, output `edge`. Reusable for button inputs.
- Top-level holds the FSM, the two counters and the output registers.

Test Plan:
- Reset check: reset=0 with random `sig_in`/`en` → freq=0, valid=0, overflow=0, busy=0; all hold 0 until en=1 after release.
- Basic count (GATE_CYCLES=100, CNT_W=32): `sig_in` period 10 cycles (5 high/5 low), en=1 → busy next cycle; valid after 101 cycles; freq=10, overflow=0.
- DC input: `sig_in` held 1 (then held 0), en=1 → freq=0 at each valid (a rise during the first window counts at most 1).
- Saturation (GATE_CYCLES=100, CNT_W=4, period 4): 25 edges in window → freq=15, overflow=1. Next window with period 10 → freq=10, overflow=0.
- Abort: en=1, then en=0 at gate cycle 50 → busy=0 next cycle, no valid, freq keeps prior value. Re-enable → full 100-cycle window, correct count.
- Continuous and reset: en held, period 10 → valid every 101 cycles, each freq=10. Assert reset at gate cycle 30 → outputs clear asynchronously, no spurious valid after release.

Source files
------------

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter_pkg
//  Purpose  : Shared types and default constants for the frequency meter.
//             state_t        - measurement FSM states
//             GATE_CYCLES_1S - one-second gate at a 50 MHz system clock
//             CNT_W_DEF      - default edge-counter / result width
//  Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int GATE_CYCLES_1S = 50000000;
  localparam int CNT_W_DEF      = 32;

endpackage
`default_nettype wire

// File: rtl/sig_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : sig_sync_edge
//  Purpose  : Multi-flop synchroniser for an asynchronous input followed by a
//             rising-edge detector. Reusable for push-button style inputs.
//  Ports    : clk      - sampling clock
//             rst_n    - asynchronous active-low reset
//             sig_in   - asynchronous input
//             edge_det - high for one cycle after a synchronised 0->1 rise
//  Revision : 1.0 - initial release
// ============================================================================
module sig_sync_edge
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Edge is combinational off two registers, so it is clean and is consumed
  // by the counter on the following clock edge.
  assign edge_det = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter
//  Purpose  : Counts rising edges of an external signal over a fixed gate
//             window of GATE_CYCLES clocks and publishes the count.
//  Ports    : clk_50MHz - system clock
//             reset     - asynchronous active-low reset
//             en        - measurement enable (level)
//             sig_in    - asynchronous signal under measurement
//             freq      - last completed measurement (edges per window)
//             valid     - one-cycle strobe while a new result is presented
//             overflow  - last completed measurement saturated
//             busy      - a window is open or its result is being latched
//  Revision : 1.0 - initial release
// ============================================================================
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_1S,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int                GATE_W      = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] C_GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = '1;

  state_t            r_state;
  state_t            w_next_state;
  logic [GATE_W-1:0] r_gate_cnt;
  logic [CNT_W-1:0]  r_edge_cnt;
  logic              r_sat;

  logic              w_edge;
  logic              w_gate_last;
  logic              w_at_max;
  logic              w_counting;
  logic              w_latch;
  logic [CNT_W-1:0]  w_final_cnt;
  logic              w_final_sat;

  sig_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk_50MHz),
    .rst_n    (reset),
    .sig_in   (sig_in),
    .edge_det (w_edge)
  );

  assign w_gate_last = (r_gate_cnt == C_GATE_LAST);
  assign w_at_max    = (r_edge_cnt == C_CNT_MAX);
  // Dropping en aborts the window, even on its final cycle.
  assign w_counting  = (r_state == GATE) && en && !w_gate_last;
  assign w_latch     = (r_state == GATE) && en && w_gate_last;

  // The edge seen on the last gate cycle still belongs to the window, so the
  // published value folds it in rather than reading the stale counter.
  assign w_final_cnt = (w_edge && !w_at_max) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_final_sat = r_sat | (w_edge & w_at_max);

  // State register
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (en) w_next_state = GATE;
      end
      GATE: begin
        if (!en)              w_next_state = IDLE;
        else if (w_gate_last) w_next_state = LATCH;
      end
      LATCH: begin
        w_next_state = en ? GATE : IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    valid = (r_state == LATCH);
    busy  = (r_state != IDLE);
  end

  // Gate and edge counters: run only inside an open window, otherwise held
  // clear (idle, abort, window end, and the dead latch cycle).
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end else if (w_counting) begin
      r_gate_cnt <= r_gate_cnt + GATE_W'(1);
      if (w_edge) begin
        if (w_at_max) r_sat      <= 1'b1;
        else          r_edge_cnt <= r_edge_cnt + CNT_W'(1);
      end
    end else begin
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
    end
  end

  // Result registers, loaded as the FSM enters LATCH
  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      freq     <= '0;
      overflow <= 1'b0;
    end else if (w_latch) begin
      freq     <= w_final_cnt;
      overflow <= w_final_sat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meter
//  Purpose  : Self-checking bench for freq_meter. Two instances share the
//             stimulus: A (GATE_CYCLES=100, CNT_W=32) and B (GATE_CYCLES=100,
//             CNT_W=4, saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int G   = 100;
  localparam int S   = 2;
  localparam int TMO = 400;
  localparam int NV  = 10;

  typedef struct {
    int          mode;     // 0 hold low, 1 hold high, 2 periodic
    int          period;
    int          high;
    logic [31:0] exp_a;
    logic [3:0]  exp_b;
    logic        exp_ovf_b;
  } vec_t;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic en     = 1'b0;
  logic sig_in = 1'b0;

  logic [31:0] freq_a;
  logic        valid_a, overflow_a, busy_a;
  logic [3:0]  freq_b;
  logic        valid_b, overflow_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(S)) dut_a (
    .clk_50MHz (clk), .reset (reset), .en (en), .sig_in (sig_in),
    .freq (freq_a), .valid (valid_a), .overflow (overflow_a), .busy (busy_a)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut_b (
    .clk_50MHz (clk), .reset (reset), .en (en), .sig_in (sig_in),
    .freq (freq_b), .valid (valid_b), .overflow (overflow_b), .busy (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns how many falling edges elapsed until valid_a was seen (0 = none)
  task automatic wait_valid(output int waited);
    waited = 0;
    for (int i = 1; i <= TMO; i++) begin
      @(negedge clk);
      if (valid_a === 1'b1) begin
        waited = i;
        break;
      end
    end
    n_tests++;
    if (waited == 0) begin
      n_fail++;
      $display("FAIL wait_valid: actual=no valid in %0d cycles required=valid", TMO);
    end
  endtask

  // ---------------- sig_in generator (changes on falling edges) -----------
  int gen_mode   = 0;
  int gen_period = 10;
  int gen_high   = 5;
  int gen_phase  = 0;
  int gen_run    = 0;

  always @(negedge clk) begin
    case (gen_mode)
      0: sig_in = 1'b0;
      1: sig_in = 1'b1;
      2: begin
        sig_in    = (gen_phase < gen_high);
        gen_phase = (gen_phase + 1) % gen_period;
      end
      default: begin
        if (gen_run > 1) gen_run--;
        else begin
          sig_in  = ~sig_in;
          gen_run = $urandom_range(1, 6);
        end
      end
    endcase
  end

  // ---------------- reference model ---------------------------------------
  // A window opened at clock index w counts the rising edges of the sampled
  // input whose detection lands on clocks w+1..w+G; detection of a rise first
  // sampled at clock k happens at clock k+S.
  bit          s_hist [0:255];
  int          cyc     = 0;
  int          m_phase = 0;   // 0 idle, 1 window open, 2 result presented
  int          wstart  = 0;
  logic        ea_valid = 1'b0;
  logic        ea_busy  = 1'b0;
  logic [31:0] ea_freq  = '0;
  logic [3:0]  eb_freq  = '0;
  logic        eb_ovf   = 1'b0;

  always @(posedge clk) begin
    int cnt;
    cyc++;
    s_hist[cyc & 255] = reset ? sig_in : 1'b0;
    ea_valid = 1'b0;
    if (!reset) begin
      m_phase = 0;
      ea_freq = '0;
      eb_freq = '0;
      eb_ovf  = 1'b0;
    end else begin
      case (m_phase)
        0: if (en) begin m_phase = 1; wstart = cyc; end
        1: begin
          if (!en) m_phase = 0;
          else if (cyc - wstart == G) begin
            cnt = 0;
            for (int q = wstart + 1; q <= cyc; q++)
              if (s_hist[(q - S) & 255] && !s_hist[(q - S - 1) & 255]) cnt++;
            ea_freq  = 32'(cnt);
            eb_freq  = (cnt > 15) ? 4'd15 : 4'(cnt);
            eb_ovf   = (cnt > 15);
            ea_valid = 1'b1;
            m_phase  = 2;
          end
        end
        default: begin
          if (en) begin m_phase = 1; wstart = cyc; end
          else m_phase = 0;
        end
      endcase
    end
    ea_busy = (m_phase != 0);
  end

  always @(negedge clk) begin
    if (reset) begin
      check("mon_a", {valid_a, busy_a, overflow_a, freq_a}, {ea_valid, ea_busy, 1'b0, ea_freq});
      check("mon_b", {valid_b, busy_b, overflow_b, freq_b}, {ea_valid, ea_busy, eb_ovf, eb_freq});
    end else begin
      check("mon_rst_a", {valid_a, busy_a, overflow_a, freq_a}, '0);
      check("mon_rst_b", {valid_b, busy_b, overflow_b, freq_b}, '0);
    end
  end

  // ---------------- directed and random sequences -------------------------
  initial begin
    int   w;
    int   nvalid;
    vec_t vecs [NV];

    vecs[0] = '{2, 10,  5, 32'd10, 4'd10, 1'b0};
    vecs[1] = '{2,  4,  2, 32'd25, 4'd15, 1'b1};
    vecs[2] = '{2, 10,  5, 32'd10, 4'd10, 1'b0};
    vecs[3] = '{2,  2,  1, 32'd50, 4'd15, 1'b1};
    vecs[4] = '{2,  5,  2, 32'd20, 4'd15, 1'b1};
    vecs[5] = '{2, 20,  3, 32'd5,  4'd5,  1'b0};
    vecs[6] = '{2, 25, 24, 32'd4,  4'd4,  1'b0};
    vecs[7] = '{2, 50,  1, 32'd2,  4'd2,  1'b0};
    vecs[8] = '{1,  1,  0, 32'd0,  4'd0,  1'b0};
    vecs[9] = '{0,  1,  0, 32'd0,  4'd0,  1'b0};

    // Reset held with random activity on the inputs
    reset    = 1'b0;
    gen_mode = 3;
    repeat (20) begin
      @(negedge clk);
      en = 1'($urandom_range(0, 1));
    end
    check("rst_outputs_a", {valid_a, busy_a, overflow_a, freq_a}, '0);
    check("rst_outputs_b", {valid_b, busy_b, overflow_b, freq_b}, '0);
    @(negedge clk);
    en    = 1'b0;
    reset = 1'b1;
    cycles(20);
    check("idle_after_release", {valid_a, busy_a, overflow_a, freq_a}, '0);

    // Basic count, period 10
    gen_period = 10; gen_high = 5; gen_phase = 0; gen_mode = 2;
    cycles(7);
    en = 1'b1;
    @(negedge clk);
    check("busy_next_cycle", busy_a, 1'b1);
    wait_valid(w);
    check("first_latency", w + 1, G + 1);
    check("basic_freq_a", freq_a, 32'd10);
    check("basic_ovf_a", overflow_a, 1'b0);
    check("basic_freq_b", freq_b, 4'd10);

    // Continuous spacing
    wait_valid(w);
    check("cont_spacing", w, G + 1);
    check("cont_freq_a", freq_a, 32'd10);

    // Table: change waveform, discard the straddling window, check the next
    for (int i = 0; i < NV; i++) begin
      gen_mode   = vecs[i].mode;
      gen_period = vecs[i].period;
      gen_high   = vecs[i].high;
      gen_phase  = 0;
      wait_valid(w);
      wait_valid(w);
      check($sformatf("tbl%0d_spacing", i), w, G + 1);
      check($sformatf("tbl%0d_freq_a", i), freq_a, vecs[i].exp_a);
      check($sformatf("tbl%0d_ovf_a", i), overflow_a, 1'b0);
      check($sformatf("tbl%0d_freq_b", i), freq_b, vecs[i].exp_b);
      check($sformatf("tbl%0d_ovf_b", i), overflow_b, vecs[i].exp_ovf_b);
    end

    // Abort mid-window keeps the previous result (25 from period 4)
    gen_period = 4; gen_high = 2; gen_phase = 0; gen_mode = 2;
    wait_valid(w);
    wait_valid(w);
    check("pre_abort_freq_a", freq_a, 32'd25);
    gen_period = 10; gen_high = 5; gen_phase = 0;
    cycles(50);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_a, 1'b0);
    nvalid = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid_a) nvalid++;
    end
    check("abort_no_valid", nvalid, 0);
    check("abort_freq_kept", freq_a, 32'd25);
    check("abort_ovf_b_kept", overflow_b, 1'b1);
    en = 1'b1;
    wait_valid(w);
    check("reenable_latency", w, G + 1);
    check("reenable_freq_a", freq_a, 32'd10);
    check("reenable_ovf_b", overflow_b, 1'b0);

    // Reset during an open window clears asynchronously
    wait_valid(w);
    cycles(30);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_rst_a", {valid_a, busy_a, overflow_a, freq_a}, '0);
    check("async_rst_b", {valid_b, busy_b, overflow_b, freq_b}, '0);
    en = 1'b0;
    cycles(5);
    reset = 1'b1;
    nvalid = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid_a) nvalid++;
    end
    check("post_rst_no_valid", nvalid, 0);
    en = 1'b1;
    wait_valid(w);
    check("post_rst_latency", w, G + 1);
    check("post_rst_freq_a", freq_a, 32'd10);

    // Random input runs with random enable gaps and occasional resets
    gen_mode = 3;
    for (int k = 0; k < 30; k++) begin
      en = 1'b1;
      cycles($urandom_range(20, 350));
      en = 1'b0;
      cycles($urandom_range(1, 20));
      if ($urandom_range(0, 7) == 0) begin
        #2 reset = 1'b0;
        cycles(4);
        reset = 1'b1;
      end
    end
    en = 1'b0;
    cycles(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
